// File: rtl/iobuf_turnaround_ctrl.sv
// Half-duplex IOBUF bank sequencer: arbitrates one writer and one reader onto a shared tristate bus.
// Latency: write drives PAD_T low from the cycle after grant for DRIVE_CYC cycles; read data appears RD_WAIT+1 cycles after grant.
// Backpressure: requests are level-held; anything raised while BUSY waits and is arbitrated in IDLE (alternating priority on ties).
//
// Ports: CLK/RST_N (async active-low); WR_REQ/WR_DATA/WR_ACK write side; RD_REQ/RD_DATA/RD_VALID read side;
//        BUSY status; PAD_I/PAD_T drive the IOBUF I/T pins, PAD_O returns the IOBUF O pins.
module iobuf_turnaround_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DRIVE_CYC = 2,
    parameter int RD_WAIT   = 1,
    parameter int TURN      = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             WR_REQ,
    input  logic [WIDTH-1:0] WR_DATA,
    output logic             WR_ACK,
    input  logic             RD_REQ,
    output logic [WIDTH-1:0] RD_DATA,
    output logic             RD_VALID,
    output logic             BUSY,
    output logic [WIDTH-1:0] PAD_I,
    output logic             PAD_T,
    input  logic [WIDTH-1:0] PAD_O
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] RWAIT = 2'd2;
    localparam logic [1:0] TURNA = 2'd3;

    localparam int MAX_A   = (DRIVE_CYC > RD_WAIT) ? DRIVE_CYC : RD_WAIT;
    localparam int MAX_CYC = (MAX_A > TURN) ? MAX_A : TURN;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;

    // Counters hold "cycles remaining minus one" in the current state.
    localparam logic [CW-1:0] DRV_LOAD = CW'(DRIVE_CYC - 1);
    localparam logic [CW-1:0] RWT_LOAD = CW'(RD_WAIT - 1);
    localparam logic [CW-1:0] TRN_LOAD = CW'((TURN > 0) ? TURN - 1 : 0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // With no turnaround the bus is released straight back to IDLE.
    localparam logic [1:0] POST_XACT = (TURN > 0) ? TURNA : IDLE;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_wr_q, last_wr_d;
    logic [WIDTH-1:0] pad_i_q, pad_i_d;
    logic             pad_t_q, pad_t_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             wr_ack_q, wr_ack_d;
    logic             busy_q, busy_d;
    logic             grant_wr, grant_rd;

    // Tie goes to whichever side was not granted last.
    assign grant_wr = WR_REQ && (!RD_REQ || !last_wr_q);
    assign grant_rd = RD_REQ && !grant_wr;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_wr_d  = last_wr_q;
        pad_i_d    = pad_i_q;
        pad_t_d    = pad_t_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                pad_t_d = 1'b1;
                pad_i_d = '0;
                if (grant_wr) begin
                    state_d   = DRIVE;
                    cnt_d     = DRV_LOAD;
                    pad_i_d   = WR_DATA;
                    pad_t_d   = 1'b0;
                    last_wr_d = 1'b1;
                end else if (grant_rd) begin
                    state_d   = RWAIT;
                    cnt_d     = RWT_LOAD;
                    last_wr_d = 1'b0;
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    pad_t_d = 1'b1;
                    pad_i_d = '0;
                    state_d = POST_XACT;
                    cnt_d   = TRN_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RWAIT: begin
                if (cnt_q == '0) begin
                    rd_data_d  = PAD_O;
                    rd_valid_d = 1'b1;
                    state_d    = POST_XACT;
                    cnt_d      = TRN_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            TURNA: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                pad_t_d = 1'b1;
                pad_i_d = '0;
            end
        endcase

        // Registered ack lands in the final DRIVE cycle (covers DRIVE_CYC=1 at grant).
        wr_ack_d = (state_d == DRIVE) && (cnt_d == '0);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_wr_q  <= 1'b0;
            pad_i_q    <= '0;
            pad_t_q    <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_ack_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_wr_q  <= last_wr_d;
            pad_i_q    <= pad_i_d;
            pad_t_q    <= pad_t_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_ack_q   <= wr_ack_d;
            busy_q     <= busy_d;
        end
    end

    assign WR_ACK   = wr_ack_q;
    assign RD_DATA  = rd_data_q;
    assign RD_VALID = rd_valid_q;
    assign BUSY     = busy_q;
    assign PAD_I    = pad_i_q;
    assign PAD_T    = pad_t_q;

endmodule

// File: tb/tb_iobuf_turnaround_ctrl.sv
module tb_iobuf_turnaround_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // default-parameter instance
    logic       wr_req = 1'b0, rd_req = 1'b0;
    logic [7:0] wr_data = 8'h00, pad_o = 8'h00;
    logic       wr_ack, rd_valid, busy, pad_t;
    logic [7:0] rd_data, pad_i;

    // DRIVE_CYC=1, TURN=0 instance
    logic       wr_req_b = 1'b0, rd_req_b = 1'b0;
    logic [7:0] wr_data_b = 8'h00, pad_o_b = 8'h00;
    logic       wr_ack_b, rd_valid_b, busy_b, pad_t_b;
    logic [7:0] rd_data_b, pad_i_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    iobuf_turnaround_ctrl dut (
        .CLK(clk), .RST_N(rst_n),
        .WR_REQ(wr_req), .WR_DATA(wr_data), .WR_ACK(wr_ack),
        .RD_REQ(rd_req), .RD_DATA(rd_data), .RD_VALID(rd_valid),
        .BUSY(busy), .PAD_I(pad_i), .PAD_T(pad_t), .PAD_O(pad_o)
    );

    iobuf_turnaround_ctrl #(.WIDTH(8), .DRIVE_CYC(1), .RD_WAIT(1), .TURN(0)) dut_b (
        .CLK(clk), .RST_N(rst_n),
        .WR_REQ(wr_req_b), .WR_DATA(wr_data_b), .WR_ACK(wr_ack_b),
        .RD_REQ(rd_req_b), .RD_DATA(rd_data_b), .RD_VALID(rd_valid_b),
        .BUSY(busy_b), .PAD_I(pad_i_b), .PAD_T(pad_t_b), .PAD_O(pad_o_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    int   g_cyc [4];
    logic g_wr  [4];
    int   ng, ack_cnt, rv_cnt, rd_bad, viol;
    logic prev_busy, prev_t, rwait_prev, rwait_now;

    initial begin
        // ---------------- reset ----------------
        step(); step();
        chk("rst_pad_t_held", 32'(pad_t), 32'd1);
        rst_n = 1'b1;
        step();
        chk("rst_pad_t", 32'(pad_t), 32'd1);
        chk("rst_pad_i", 32'(pad_i), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'h00);
        chk("rst_wr_ack", 32'(wr_ack), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);

        // ---------------- single write ----------------
        wr_req = 1'b1; wr_data = 8'hA5;
        step();
        chk("wr_c1_pad_t", 32'(pad_t), 32'd0);
        chk("wr_c1_pad_i", 32'(pad_i), 32'hA5);
        chk("wr_c1_ack", 32'(wr_ack), 32'd0);
        chk("wr_c1_busy", 32'(busy), 32'd1);
        wr_data = 8'h00;  // don't-care after grant
        step();
        chk("wr_c2_pad_t", 32'(pad_t), 32'd0);
        chk("wr_c2_pad_i", 32'(pad_i), 32'hA5);
        chk("wr_c2_ack", 32'(wr_ack), 32'd1);
        wr_req = 1'b0;
        step();
        chk("wr_t1_pad_t", 32'(pad_t), 32'd1);
        chk("wr_t1_pad_i", 32'(pad_i), 32'h00);
        chk("wr_t1_ack", 32'(wr_ack), 32'd0);
        chk("wr_t1_busy", 32'(busy), 32'd1);
        step();
        chk("wr_t2_pad_t", 32'(pad_t), 32'd1);
        chk("wr_t2_busy", 32'(busy), 32'd1);
        step();
        chk("wr_idle_busy", 32'(busy), 32'd0);

        // ---------------- single read ----------------
        rd_req = 1'b1; pad_o = 8'h3C;
        step();
        chk("rd_w_pad_t", 32'(pad_t), 32'd1);
        chk("rd_w_busy", 32'(busy), 32'd1);
        chk("rd_w_valid", 32'(rd_valid), 32'd0);
        step();
        chk("rd_v_valid", 32'(rd_valid), 32'd1);
        chk("rd_v_data", 32'(rd_data), 32'h3C);
        chk("rd_v_pad_t", 32'(pad_t), 32'd1);
        rd_req = 1'b0; pad_o = 8'h00;
        step();
        chk("rd_t2_valid", 32'(rd_valid), 32'd0);
        chk("rd_t2_hold", 32'(rd_data), 32'h3C);
        chk("rd_t2_busy", 32'(busy), 32'd1);
        step();
        chk("rd_idle_busy", 32'(busy), 32'd0);

        // ---------------- tie / alternation ----------------
        wr_req = 1'b1; rd_req = 1'b1; wr_data = 8'hA5; pad_o = 8'h3C;
        ng = 0; ack_cnt = 0; rv_cnt = 0; rd_bad = 0; viol = 0;
        for (int i = 0; i < 4; i++) begin g_cyc[i] = 0; g_wr[i] = 1'b0; end
        prev_busy = busy; prev_t = pad_t; rwait_prev = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            step();
            if (wr_ack) ack_cnt++;
            if (rd_valid) begin
                rv_cnt++;
                if (rd_data !== 8'h3C) rd_bad++;
            end
            if (rwait_prev && pad_t !== 1'b1) viol++;
            rwait_now = 1'b0;
            if (busy && !prev_busy && ng < 4) begin
                g_cyc[ng] = c;
                g_wr[ng]  = !pad_t;
                if (pad_t) begin
                    rwait_now = 1'b1;
                    if (prev_t !== 1'b1) viol++;
                end
                ng++;
                if (ng == 4) begin wr_req = 1'b0; rd_req = 1'b0; end
            end
            rwait_prev = rwait_now;
            prev_busy  = busy;
            prev_t     = pad_t;
            if (ng == 4 && !busy) break;
        end
        chk("tie_grants", 32'(ng), 32'd4);
        chk("tie_order0_w", 32'(g_wr[0]), 32'd1);
        chk("tie_order1_r", 32'(g_wr[1]), 32'd0);
        chk("tie_order2_w", 32'(g_wr[2]), 32'd1);
        chk("tie_order3_r", 32'(g_wr[3]), 32'd0);
        chk("tie_gap_wr", 32'(g_cyc[1] - g_cyc[0]), 32'd5);
        chk("tie_gap_rw", 32'(g_cyc[2] - g_cyc[1]), 32'd4);
        chk("tie_gap_wr2", 32'(g_cyc[3] - g_cyc[2]), 32'd5);
        chk("tie_ack_cnt", 32'(ack_cnt), 32'd2);
        chk("tie_valid_cnt", 32'(rv_cnt), 32'd2);
        chk("tie_rd_data_bad", 32'(rd_bad), 32'd0);
        chk("tie_rwait_overlap", 32'(viol), 32'd0);
        chk("tie_end_busy", 32'(busy), 32'd0);

        // ---------------- boundary: DRIVE_CYC=1, TURN=0 ----------------
        wr_req_b = 1'b1; wr_data_b = 8'h01;
        step();
        chk("b_w1_pad_t", 32'(pad_t_b), 32'd0);
        chk("b_w1_pad_i", 32'(pad_i_b), 32'h01);
        chk("b_w1_ack", 32'(wr_ack_b), 32'd1);
        wr_data_b = 8'h02;
        step();
        chk("b_gap_pad_t", 32'(pad_t_b), 32'd1);
        chk("b_gap_ack", 32'(wr_ack_b), 32'd0);
        chk("b_gap_busy", 32'(busy_b), 32'd0);
        chk("b_gap_pad_i", 32'(pad_i_b), 32'h00);
        step();
        chk("b_w2_pad_t", 32'(pad_t_b), 32'd0);
        chk("b_w2_pad_i", 32'(pad_i_b), 32'h02);
        chk("b_w2_ack", 32'(wr_ack_b), 32'd1);
        wr_req_b = 1'b0;
        step();
        chk("b_end_pad_t", 32'(pad_t_b), 32'd1);
        chk("b_end_ack", 32'(wr_ack_b), 32'd0);
        chk("b_end_busy", 32'(busy_b), 32'd0);

        // ---------------- reset mid-write ----------------
        wr_req = 1'b1; wr_data = 8'h5A;
        step();
        chk("mr_drive_pad_t", 32'(pad_t), 32'd0);
        #2;
        rst_n = 1'b0; wr_req = 1'b0;
        #1;
        chk("mr_async_pad_t", 32'(pad_t), 32'd1);
        chk("mr_async_pad_i", 32'(pad_i), 32'h00);
        chk("mr_async_busy", 32'(busy), 32'd0);
        chk("mr_async_ack", 32'(wr_ack), 32'd0);
        step();
        chk("mr_no_ack", 32'(wr_ack), 32'd0);
        rst_n = 1'b1;
        step();
        // tie after reset: write must win again
        wr_req = 1'b1; rd_req = 1'b1; wr_data = 8'h77; pad_o = 8'h96;
        step();
        chk("mr_w_pad_t", 32'(pad_t), 32'd0);
        chk("mr_w_pad_i", 32'(pad_i), 32'h77);
        step();
        chk("mr_w_ack", 32'(wr_ack), 32'd1);
        wr_req = 1'b0;
        step(); step();
        chk("mr_turn_busy", 32'(busy), 32'd1);
        step();
        chk("mr_idle_busy", 32'(busy), 32'd0);
        step();
        chk("mr_rwait_pad_t", 32'(pad_t), 32'd1);
        step();
        chk("mr_rd_valid", 32'(rd_valid), 32'd1);
        chk("mr_rd_data", 32'(rd_data), 32'h96);
        rd_req = 1'b0;
        step(); step();
        chk("mr_end_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iobuf_turnaround_ctrl.md
Name: iobuf_turnaround_ctrl

Overview:
- Sequences a WIDTH-bit bank of bidirectional IOBUF cells (I, T, O per bit) that carry a half-duplex parallel bus to an external device.
- Arbitrates between one write requester and one read requester, and controls the shared tristate enable.
- Inserts a sample-wait before each read and a turnaround gap after every transaction, so our driver and the external driver never overlap.
- Sits between the core-side logic and the IOBUF instances: PAD_I drives their I pins, PAD_T their T pins, and PAD_O comes from their O pins.

Parameters:
- WIDTH, 8: bus width in bits.
- DRIVE_CYC, 2: cycles the bus is driven per write; must be >= 1.
- RD_WAIT, 1: released-bus cycles before a read samples PAD_O; must be >= 1.
- TURN, 2: released-bus turnaround cycles after every transaction; must be >= 0.

Ports:
- CLK  input  1  single clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- WR_REQ  input  1  write request, level; held high until WR_ACK.
- WR_DATA  input  WIDTH  write data, captured at grant.
- WR_ACK  output  1  one-cycle write-complete pulse.
- RD_REQ  input  1  read request, level; held high until RD_VALID.
- RD_DATA  output  WIDTH  last sampled read data, held until the next read.
- RD_VALID  output  1  one-cycle pulse; RD_DATA is new this cycle.
- BUSY  output  1  high whenever the FSM is not in IDLE.
- PAD_I  output  WIDTH  data to the IOBUF I pins.
- PAD_T  output  1  tristate to the IOBUF T pins; 1 = released, 0 = driving.
- PAD_O  input  WIDTH  IOBUF O pins; bus value as seen at the pad.

Behaviour:
- Reset: asynchronous on RST_N=0, effective immediately, including mid-transaction.
  - PAD_T=1, PAD_I=0, WR_ACK=0, RD_VALID=0, RD_DATA=0, BUSY=0.
  - FSM goes to IDLE; last_grant=RD, so a write wins the first tie.
- All outputs are registered; there is no combinational path from inputs to outputs.
- FSM states: IDLE, DRIVE, RWAIT, TURNA.
- Every counter is sized to hold max(DRIVE_CYC, RD_WAIT, TURN).
- E0 denotes the edge at which IDLE grants a request.
- IDLE:
  - PAD_T=1; requests are sampled each edge.
  - Only WR_REQ: grant the write. Only RD_REQ: grant the read.
  - Both: grant the one that is not last_grant (alternating priority), then update last_grant.
- Write (grant at E0):
  - At E0: PAD_I<=WR_DATA, PAD_T<=0, go to DRIVE.
  - PAD_T=0 for exactly DRIVE_CYC cycles; PAD_I is stable for the whole window.
  - WR_ACK=1 in the last DRIVE cycle only.
  - Then PAD_T<=1 and go to TURNA, or to IDLE if TURN=0.
  - PAD_I returns to 0 when PAD_T returns to 1.
- Read (grant at E0):
  - At E0 go to RWAIT; PAD_T stays 1 for RD_WAIT cycles.
  - At the edge ending the last RWAIT cycle: RD_DATA<=PAD_O, and RD_VALID=1 for the next cycle.
  - That next cycle is the first TURNA cycle, or an IDLE cycle if TURN=0.
- TURNA: PAD_T=1 for exactly TURN cycles, then IDLE. Requests are ignored during TURNA.
- BUSY=1 from the cycle after E0 until the FSM re-enters IDLE.
  - The earliest next grant is the edge at which BUSY is first observed 0.
- Transaction cost: write = 1 + DRIVE_CYC + TURN cycles; read = 1 + RD_WAIT + TURN cycles, measured grant to next grant.
- A request dropped after grant does not abort the transaction; it completes normally with its ack or valid pulse.
- A request raised while BUSY is held pending and is arbitrated in IDLE.
- WR_DATA and PAD_O are don't-care outside their capture edges.
- Invariant: PAD_T=0 only in DRIVE. There is never a cycle with PAD_T=0 adjacent to an RWAIT cycle.

Test Plan:
- Reset values: hold RST_N=0, then release → PAD_T=1, PAD_I=0, BUSY=0, RD_DATA=0, WR_ACK=0, RD_VALID=0.
- Single write (defaults): WR_REQ=1, WR_DATA=0xA5 → PAD_T=0 and PAD_I=0xA5 for 2 cycles; WR_ACK in the 2nd; PAD_T=1 and BUSY=1 for 2 cycles; then BUSY=0.
- Single read (defaults): RD_REQ=1, PAD_O=0x3C → PAD_T never 0; RD_DATA=0x3C with RD_VALID pulsed 2 cycles after grant; BUSY=0 after 2 turnaround cycles.
- Tie and alternation: WR_REQ and RD_REQ held high together, with the same PAD_O and WR_DATA values as above → grant order W, R, W, R; grants exactly 5 and 4 cycles apart; no cycle with PAD_T=0 during RWAIT.
- Boundary (TURN=0, DRIVE_CYC=1): back-to-back writes 0x01, 0x02 → PAD_T low 1 cycle each with 1 idle cycle between; WR_ACK pulses 2 cycles apart.
- Reset mid-write: RST_N=0 during the DRIVE cycle → PAD_T=1 in the same cycle, without waiting for CLK; no WR_ACK; after release, a new write completes normally.
